// File: rtl/serial_link_pkg.sv
// Shared definitions for the single-wire serial link: FSM states, line levels, width helper.
// Also imported by the matching receiver so both ends agree on line levels.
package serial_link_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } link_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Counter width for a modulus of n; never narrower than one bit.
   function automatic int width_of(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Word-in / line-out bundle of the frame transmitter.
// The master modport supplies words; the slave modport is the transmitter.
interface serial_frame_tx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] DIN;
   logic              DIN_VALID;
   logic              DIN_READY;
   logic              TXD;
   logic              BUSY;
   logic              DONE;

   modport master (
      output DIN, DIN_VALID,
      input  DIN_READY, TXD, BUSY, DONE
   );

   modport slave (
      input  DIN, DIN_VALID,
      output DIN_READY, TXD, BUSY, DONE
   );
endinterface

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, pulses wrap on the last count.
// Held at zero while disabled so every frame starts on a fresh bit period.
module bit_timer
   import serial_link_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic wrap
);
   localparam int            CW   = width_of(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   assign wrap = en && (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!en || wrap) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end
endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W bits LSB first, optional even parity, stop bit.
// Parity bit is present only when SERIAL_FRAME_TX_PARITY_EN is defined.
module serial_frame_tx
   import serial_link_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              CLK,
   input  logic              RST,
   serial_frame_tx_if.slave  tx
);
   localparam int            IW       = width_of(DATA_W);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

   link_state_t       state, state_n;
   logic [DATA_W-1:0] shift_q, shift_n, shifted;
   logic [IW-1:0]     bit_idx, bit_idx_n;
   logic              txd_q, txd_n;
   logic              done_q, done_n;
   logic              timer_en;
   logic              wrap;
`ifdef SERIAL_FRAME_TX_PARITY_EN
   logic              parity_q, parity_n;
`endif

   assign timer_en = (state != IDLE);
   assign shifted  = shift_q >> 1;

   bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk  (CLK),
      .rst  (RST),
      .en   (timer_en),
      .wrap (wrap)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         shift_q <= '0;
         bit_idx <= '0;
         txd_q   <= LINE_IDLE;
         done_q  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         shift_q <= shift_n;
         bit_idx <= bit_idx_n;
         txd_q   <= txd_n;
         done_q  <= done_n;
`ifdef SERIAL_FRAME_TX_PARITY_EN
         parity_q <= parity_n;
`endif
      end
   end

   // TXD is registered, so each branch loads the level the line must show in the next state.
   always_comb begin
      state_n   = state;
      shift_n   = shift_q;
      bit_idx_n = bit_idx;
      txd_n     = txd_q;
      done_n    = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      parity_n  = parity_q;
`endif
      case (state)
         IDLE: begin
            txd_n = LINE_IDLE;
            if (tx.DIN_VALID) begin
               state_n   = START;
               shift_n   = tx.DIN;
               bit_idx_n = '0;
               txd_n     = START_BIT;
`ifdef SERIAL_FRAME_TX_PARITY_EN
               parity_n  = ^tx.DIN;
`endif
            end
         end
         START: begin
            if (wrap) begin
               state_n = DATA;
               txd_n   = shift_q[0];
            end
         end
         DATA: begin
            if (wrap) begin
               if (bit_idx == LAST_BIT) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                  state_n = PARITY;
                  txd_n   = parity_q;
`else
                  state_n = STOP;
                  txd_n   = STOP_BIT;
`endif
               end else begin
                  shift_n   = shifted;
                  txd_n     = shifted[0];
                  bit_idx_n = bit_idx + IW'(1);
               end
            end
         end
`ifdef SERIAL_FRAME_TX_PARITY_EN
         PARITY: begin
            if (wrap) begin
               state_n = STOP;
               txd_n   = STOP_BIT;
            end
         end
`endif
         STOP: begin
            if (wrap) begin
               state_n = IDLE;
               txd_n   = LINE_IDLE;
               done_n  = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            txd_n   = LINE_IDLE;
         end
      endcase
   end

   assign tx.DIN_READY = (state == IDLE);
   assign tx.BUSY      = (state != IDLE);
   assign tx.TXD       = txd_q;
   assign tx.DONE      = done_q;
endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: directed and random frames compared cycle by cycle against a bit-list model.
// Follows SERIAL_FRAME_TX_PARITY_EN the same way the design does.
module tb_serial_frame_tx;
   localparam int DATA_W = 8;
   localparam int C      = 4;

   typedef bit bitq_t[$];

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   passed = 0;
   int   total  = 0;

   serial_frame_tx_if #(.DATA_W(DATA_W)) bus ();

   serial_frame_tx #(
      .DATA_W       (DATA_W),
      .CLKS_PER_BIT (C)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .tx  (bus)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Line levels of one frame, one entry per bit period.
   function automatic bitq_t frame_bits(input logic [DATA_W-1:0] w);
      bitq_t q;
      q.push_back(1'b0);
      for (int i = 0; i < DATA_W; i++) q.push_back(w[i]);
`ifdef SERIAL_FRAME_TX_PARITY_EN
      q.push_back(^w);
`endif
      q.push_back(1'b1);
      return q;
   endfunction

   // Called just after a falling edge; returns at the falling edge inside the DONE cycle.
   task automatic send_frame(input logic [DATA_W-1:0] w, input bit hold,
                             input bit glitch, input logic [DATA_W-1:0] gval, input string tag);
      bitq_t bits;
      int    cyc;
      bits = frame_bits(w);
      cyc  = 0;
      bus.DIN       = w;
      bus.DIN_VALID = 1'b1;
      check({tag, " ready_before"}, bus.DIN_READY, 1);
      @(posedge CLK);
      foreach (bits[i]) begin
         for (int c = 0; c < C; c++) begin
            @(negedge CLK);
            if (cyc == 0 && !hold) bus.DIN_VALID = 1'b0;
            if (glitch && cyc == 3 * C) bus.DIN = gval;
            check({tag, " txd"}, bus.TXD, bits[i]);
            check({tag, " busy"}, bus.BUSY, 1);
            check({tag, " ready_busy"}, bus.DIN_READY, 0);
            check({tag, " done_busy"}, bus.DONE, 0);
            cyc++;
         end
      end
      @(negedge CLK);
      check({tag, " done"}, bus.DONE, 1);
      check({tag, " busy_end"}, bus.BUSY, 0);
      check({tag, " ready_end"}, bus.DIN_READY, 1);
      check({tag, " txd_end"}, bus.TXD, 1);
   endtask

   task automatic idle_cycles(input int n, input string tag);
      bus.DIN_VALID = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(negedge CLK);
         check({tag, " idle_txd"}, bus.TXD, 1);
         check({tag, " idle_busy"}, bus.BUSY, 0);
         check({tag, " idle_done"}, bus.DONE, 0);
      end
   endtask

   initial begin
      logic [DATA_W-1:0] w;
      bit                hold;

      bus.DIN       = '0;
      bus.DIN_VALID = 1'b0;
      RST           = 1'b1;

      // Reset held for three cycles, then released.
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst txd", bus.TXD, 1);
      check("rst ready", bus.DIN_READY, 1);
      check("rst busy", bus.BUSY, 0);
      check("rst done", bus.DONE, 0);
      RST = 1'b0;
      idle_cycles(2, "post_rst");

      send_frame(8'hA5, 1'b0, 1'b0, '0, "a5");
      idle_cycles(2, "a5");

      // Valid held: the second word goes out after exactly one idle cycle.
      send_frame(8'h00, 1'b1, 1'b0, '0, "b2b_00");
      send_frame(8'hFF, 1'b1, 1'b0, '0, "b2b_ff");
      idle_cycles(2, "b2b");

      send_frame(8'hA5, 1'b0, 1'b1, 8'h3C, "din_chg");
      idle_cycles(1, "din_chg");

      // Asynchronous reset in the middle of data bit 3 of 8'h96.
      bus.DIN       = 8'h96;
      bus.DIN_VALID = 1'b1;
      @(posedge CLK);
      #1 bus.DIN_VALID = 1'b0;
      repeat (4 * C) @(posedge CLK);
      #1 check("abort pre_txd", bus.TXD, 0);
      #2 RST = 1'b1;
      #1;
      check("abort txd", bus.TXD, 1);
      check("abort busy", bus.BUSY, 0);
      check("abort ready", bus.DIN_READY, 1);
      check("abort done", bus.DONE, 0);
      @(negedge CLK);
      RST = 1'b0;
      idle_cycles(2 * C, "abort");
      send_frame(8'h5A, 1'b0, 1'b0, '0, "after_abort");
      idle_cycles(1, "after_abort");

      send_frame(8'h07, 1'b0, 1'b0, '0, "par07");
      idle_cycles(1, "par07");

      for (int n = 0; n < 8; n++) begin
         w    = DATA_W'($urandom);
         hold = 1'($urandom_range(0, 1));
         send_frame(w, hold, 1'b0, '0, "rand");
         if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3), "rand");
      end
      idle_cycles(1, "final");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
